// File: rtl/cv32e40p_ff_one_tmr_pipe.sv
// Fault-tolerant find-first/last-one unit: NREP replicated scans, majority vote,
// registered valid/ready output stage and per-replica mismatch retirement.
module cv32e40p_ff_one_tmr_pipe #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned NREP       = 3,
  parameter int unsigned FIND_LAST  = 0,
  parameter int unsigned ERR_CNT_W  = 4,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [LEN-1:0]          in_i,
  input  logic [NREP-1:0]         fault_inj_i,
  input  logic                    clear_faults_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(LEN)-1:0]  first_one_o,
  output logic                    no_ones_o,
  output logic                    mismatch_o,
  output logic                    uncorrectable_o,
  output logic [NREP-1:0]         replica_faulty_o
);

  localparam int unsigned IW = $clog2(LEN);
  localparam int unsigned CW = $clog2(NREP + 1) + 1;
  localparam logic [ERR_CNT_W-1:0] THRESH = ERR_CNT_W'(ERR_THRESH);

  // Replica result tuple packed as {idx, zero}; bit 1 is idx[0].
  typedef logic [IW:0] tuple_t;

  function automatic tuple_t scan(input logic [LEN-1:0] v);
    logic [IW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < LEN; i++) begin
      if (v[i] && ((FIND_LAST != 0) || !found)) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    return {idx, !found};
  endfunction

  tuple_t                 tup [NREP];
  tuple_t                 voted;
  logic                   unc;
  logic                   mism;
  logic                   accept;
  logic                   first_found;
  logic                   maj_found;
  logic [CW-1:0]          n_act;
  logic [CW-1:0]          n_match;

  logic                   valid_q, valid_d;
  logic [IW-1:0]          first_q, first_d;
  logic                   no_ones_q, no_ones_d;
  logic                   mism_q, mism_d;
  logic                   unc_q, unc_d;
  logic [NREP-1:0]        faulty_q, faulty_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q [NREP];
  logic [ERR_CNT_W-1:0]   err_cnt_d [NREP];

  for (genvar g = 0; g < NREP; g++) begin : g_rep
    assign tup[g] = scan(in_i) ^ tuple_t'({fault_inj_i[g], 1'b0});
  end

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  // Majority over active replicas; fallback is the lowest-index active replica,
  // or replica 0 when every replica has been retired.
  always_comb begin
    n_act = '0;
    for (int unsigned k = 0; k < NREP; k++) begin
      if (!faulty_q[k]) n_act = n_act + CW'(1);
    end
    voted       = tup[0];
    unc         = 1'b1;
    first_found = 1'b0;
    maj_found   = 1'b0;
    n_match     = '0;
    for (int unsigned k = 0; k < NREP; k++) begin
      if (!faulty_q[k] && !first_found) begin
        voted       = tup[k];
        first_found = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NREP; k++) begin
      n_match = '0;
      for (int unsigned j = 0; j < NREP; j++) begin
        if (!faulty_q[j] && (tup[j] == tup[k])) n_match = n_match + CW'(1);
      end
      if (!faulty_q[k] && !maj_found && ({n_match, 1'b0} > {1'b0, n_act})) begin
        voted     = tup[k];
        unc       = 1'b0;
        maj_found = 1'b1;
      end
    end
    mism = 1'b0;
    for (int unsigned k = 0; k < NREP; k++) begin
      if (!faulty_q[k] && (tup[k] != voted)) mism = 1'b1;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    first_d   = first_q;
    no_ones_d = no_ones_q;
    mism_d    = mism_q;
    unc_d     = unc_q;
    faulty_d  = faulty_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      valid_d   = 1'b1;
      first_d   = voted[IW:1];
      no_ones_d = voted[0];
      mism_d    = mism;
      unc_d     = unc;
      if (!unc) begin
        for (int unsigned k = 0; k < NREP; k++) begin
          if (!faulty_q[k] && (tup[k] != voted)) begin
            if (err_cnt_q[k] != '1) err_cnt_d[k] = err_cnt_q[k] + 1'b1;
            if (err_cnt_d[k] >= THRESH) faulty_d[k] = 1'b1;
          end
        end
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
    // Clear wins over a same-cycle increment; the vote above used the old set.
    if (clear_faults_i) begin
      faulty_d = '0;
      for (int unsigned k = 0; k < NREP; k++) err_cnt_d[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      first_q   <= '0;
      no_ones_q <= 1'b0;
      mism_q    <= 1'b0;
      unc_q     <= 1'b0;
      faulty_q  <= '0;
      for (int unsigned k = 0; k < NREP; k++) err_cnt_q[k] <= '0;
    end else begin
      valid_q   <= valid_d;
      first_q   <= first_d;
      no_ones_q <= no_ones_d;
      mism_q    <= mism_d;
      unc_q     <= unc_d;
      faulty_q  <= faulty_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign valid_o          = valid_q;
  assign first_one_o      = first_q;
  assign no_ones_o        = no_ones_q;
  assign mismatch_o       = mism_q;
  assign uncorrectable_o  = unc_q;
  assign replica_faulty_o = faulty_q;

endmodule

// File: tb/tb_cv32e40p_ff_one_tmr_pipe.sv
// Bench for cv32e40p_ff_one_tmr_pipe: first-one and last-one instances share
// stimulus and are checked every cycle against a tuple-vote reference model.
module tb_cv32e40p_ff_one_tmr_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic        clear_faults_i;
  logic [31:0] in_i;
  logic [2:0]  fault_inj_i;

  logic [1:0]  ready_w, valid_w, noz_w, mm_w, unc_w;
  logic [4:0]  first_w [2];
  logic [2:0]  flt_w [2];

  always #5 clk = ~clk;

  cv32e40p_ff_one_tmr_pipe #(.LEN(32), .NREP(3), .FIND_LAST(0), .ERR_CNT_W(4), .ERR_THRESH(8)) u_first (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w[0]), .in_i(in_i),
    .fault_inj_i(fault_inj_i), .clear_faults_i(clear_faults_i), .valid_o(valid_w[0]),
    .ready_i(ready_i), .first_one_o(first_w[0]), .no_ones_o(noz_w[0]), .mismatch_o(mm_w[0]),
    .uncorrectable_o(unc_w[0]), .replica_faulty_o(flt_w[0]));

  cv32e40p_ff_one_tmr_pipe #(.LEN(32), .NREP(3), .FIND_LAST(1), .ERR_CNT_W(4), .ERR_THRESH(8)) u_last (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w[1]), .in_i(in_i),
    .fault_inj_i(fault_inj_i), .clear_faults_i(clear_faults_i), .valid_o(valid_w[1]),
    .ready_i(ready_i), .first_one_o(first_w[1]), .no_ones_o(noz_w[1]), .mismatch_o(mm_w[1]),
    .uncorrectable_o(unc_w[1]), .replica_faulty_o(flt_w[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state, one slot per instance (0 = first-one, 1 = last-one).
  bit       e_valid [2];
  int       e_idx   [2];
  bit       e_zero  [2];
  bit       e_mm    [2];
  bit       e_unc   [2];
  bit [2:0] e_flt   [2];
  int       e_cnt   [2][3];
  bit       model_ok = 1'b0;
  int       n_acc = 0, n_out = 0, n_drop = 0;

  function automatic int ref_index(input bit last, input logic [31:0] v);
    if (last) begin
      for (int i = 31; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 32; i++) if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int t [3];
    int act [$];
    int r, v, win, cnt;
    bit acc, um, mm;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        if (m == 0 && e_valid[0]) n_drop++;
        e_valid[m] = 0; e_idx[m] = 0; e_zero[m] = 0; e_mm[m] = 0; e_unc[m] = 0;
        e_flt[m] = '0;
        for (int k = 0; k < 3; k++) e_cnt[m][k] = 0;
      end else begin
        acc = valid_i && (!e_valid[m] || ready_i);
        if (acc) begin
          r = ref_index(m == 1, in_i);
          for (int k = 0; k < 3; k++) begin
            t[k] = (r < 0) ? 1 : r * 2;
            if (fault_inj_i[k]) t[k] = t[k] ^ 2;
          end
          act.delete();
          for (int k = 0; k < 3; k++) if (!e_flt[m][k]) act.push_back(k);
          win = -1;
          foreach (act[a]) begin
            cnt = 0;
            foreach (act[b]) if (t[act[b]] == t[act[a]]) cnt++;
            if (cnt * 2 > act.size()) win = t[act[a]];
          end
          if (act.size() == 0) begin v = t[0]; um = 1; end
          else if (win < 0) begin v = t[act[0]]; um = 1; end
          else begin v = win; um = 0; end
          mm = 0;
          foreach (act[a]) if (t[act[a]] != v) mm = 1;
          e_valid[m] = 1; e_idx[m] = v / 2; e_zero[m] = v % 2; e_mm[m] = mm; e_unc[m] = um;
          if (!um) begin
            foreach (act[a]) begin
              if (t[act[a]] != v) begin
                if (e_cnt[m][act[a]] < 15) e_cnt[m][act[a]]++;
                if (e_cnt[m][act[a]] >= 8) e_flt[m][act[a]] = 1;
              end
            end
          end
          if (m == 0) n_acc++;
        end else if (ready_i) begin
          e_valid[m] = 0;
        end
        if (clear_faults_i) begin
          e_flt[m] = '0;
          for (int k = 0; k < 3; k++) e_cnt[m][k] = 0;
        end
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("valid_o[%0d]", m), 32'(valid_w[m]), 32'(e_valid[m]));
        chk($sformatf("ready_o[%0d]", m), 32'(ready_w[m]), 32'(!e_valid[m] || ready_i));
        chk($sformatf("first_one_o[%0d]", m), 32'(first_w[m]), 32'(e_idx[m]));
        chk($sformatf("no_ones_o[%0d]", m), 32'(noz_w[m]), 32'(e_zero[m]));
        chk($sformatf("mismatch_o[%0d]", m), 32'(mm_w[m]), 32'(e_mm[m]));
        chk($sformatf("uncorrectable_o[%0d]", m), 32'(unc_w[m]), 32'(e_unc[m]));
        chk($sformatf("replica_faulty_o[%0d]", m), 32'(flt_w[m]), 32'(e_flt[m]));
      end
      if (valid_w[0] && ready_i && !rst) n_out++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_faults_i = 1'b0;
    in_i = '0; fault_inj_i = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("lit_reset_valid", 32'(valid_w[0]), 32'd0);
    chk("lit_reset_ready", 32'(ready_w[0]), 32'd1);
    chk("lit_reset_faulty", 32'(flt_w[0]), 32'd0);

    // Basic scans
    valid_i = 1'b1; in_i = 32'h0000_1000;
    step();
    chk("lit_scan_valid", 32'(valid_w[0]), 32'd1);
    chk("lit_scan_first", 32'(first_w[0]), 32'd12);
    chk("lit_scan_nz", 32'(noz_w[0]), 32'd0);
    in_i = 32'h0;
    step();
    chk("lit_zero_first", 32'(first_w[0]), 32'd0);
    chk("lit_zero_nz", 32'(noz_w[0]), 32'd1);
    in_i = 32'h8000_0001;
    step();
    chk("lit_last_31", 32'(first_w[1]), 32'd31);
    chk("lit_first_0", 32'(first_w[0]), 32'd0);

    // One-hot sweep
    for (int i = 0; i < 32; i++) begin
      in_i = 32'h1 << i;
      step();
      chk("lit_sweep_first", 32'(first_w[0]), 32'(i));
      chk("lit_sweep_last", 32'(first_w[1]), 32'(i));
    end

    // Single-replica fault retires replica 1 after 8 mismatches
    fault_inj_i = 3'b010; in_i = 32'h10;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) begin
        chk("lit_sf_first", 32'(first_w[0]), 32'd4);
        chk("lit_sf_mm", 32'(mm_w[0]), 32'd1);
        chk("lit_sf_unc", 32'(unc_w[0]), 32'd0);
        chk("lit_sf_flt_early", 32'(flt_w[0]), 32'd0);
      end
    end
    chk("lit_sf_flt", 32'(flt_w[0]), 32'd2);
    chk("lit_sf_mm8", 32'(mm_w[0]), 32'd1);
    step();
    chk("lit_sf_mm9", 32'(mm_w[0]), 32'd0);
    chk("lit_sf_first9", 32'(first_w[0]), 32'd4);

    // Double fault with replica 1 retired: active pair disagrees
    fault_inj_i = 3'b011;
    step();
    chk("lit_df_unc", 32'(unc_w[0]), 32'd1);
    chk("lit_df_first", 32'(first_w[0]), 32'd5);
    chk("lit_df_last", 32'(first_w[1]), 32'd5);
    fault_inj_i = 3'b000; valid_i = 1'b0;
    step();

    // Backpressure
    valid_i = 1'b1; in_i = 32'h100;
    step();
    chk("lit_bp_first0", 32'(first_w[0]), 32'd8);
    ready_i = 1'b0; in_i = 32'h200;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("lit_bp_ready", 32'(ready_w[0]), 32'd0);
      chk("lit_bp_hold", 32'(first_w[0]), 32'd8);
    end
    ready_i = 1'b1;
    step();
    chk("lit_bp_next", 32'(first_w[0]), 32'd9);
    in_i = 32'h400;
    step();
    chk("lit_bp_next2", 32'(first_w[0]), 32'd10);
    valid_i = 1'b0;
    step();
    chk("lit_bp_drain", 32'(valid_w[0]), 32'd0);

    // Clear faults, then clear racing the threshold-reaching mismatch
    clear_faults_i = 1'b1;
    step();
    chk("lit_clr_flt", 32'(flt_w[0]), 32'd0);
    clear_faults_i = 1'b0; fault_inj_i = 3'b010; valid_i = 1'b1; in_i = 32'h10;
    for (int n = 0; n < 7; n++) step();
    chk("lit_clr_flt7", 32'(flt_w[0]), 32'd0);
    clear_faults_i = 1'b1;
    step();
    chk("lit_clr_mm", 32'(mm_w[0]), 32'd1);
    chk("lit_clr_prio", 32'(flt_w[0]), 32'd0);
    clear_faults_i = 1'b0;
    step();
    chk("lit_clr_after", 32'(flt_w[0]), 32'd0);

    // Reset while a result is held
    in_i = 32'h4;
    step();
    chk("lit_rst_pre_valid", 32'(valid_w[0]), 32'd1);
    chk("lit_rst_pre_mm", 32'(mm_w[0]), 32'd1);
    rst = 1'b1; valid_i = 1'b0; fault_inj_i = 3'b000;
    step();
    chk("lit_rst_valid", 32'(valid_w[0]), 32'd0);
    chk("lit_rst_first", 32'(first_w[0]), 32'd0);
    chk("lit_rst_mm", 32'(mm_w[0]), 32'd0);
    rst = 1'b0;
    step();
    chk("lit_rst_ready", 32'(ready_w[0]), 32'd1);
    step();
    chk("xfer_count", 32'(n_out + n_drop), 32'(n_acc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
